enemy_car_mover: RTL

- Sequential position generator for one enemy car in the Road Fighter display path.
- Consumes the constant spawn column produced by the upstream top-left constant stage.
- Produces the frame-by-frame signed top-left coordinate and draw enable consumed by the downstream sprite/square drawing block.
- Handles spawn, downward scroll with player-speed dependence, lateral drift between road edges, crash animation and despawn.

---
 rtl/enemy_car_if.sv | 28 ++
 rtl/enemy_car_mover.sv | 128 ++++++++++++
 2 files changed

// File: rtl/enemy_car_if.sv
// Frame-control inputs and drawing outputs of one enemy car.
// The slave side is the mover; the master side drives frame controls.
interface enemy_car_if;
  logic              startOfFrame;
  logic signed [10:0] initialX;
  logic              spawn_en;
  logic [3:0]        speed;
  logic              drift_en;
  logic              collision;
  logic              pause;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic              draw_en;
  logic              active;
  logic              crashing;

  modport master (
    output startOfFrame, initialX, spawn_en, speed,
    output drift_en, collision, pause,
    input  topLeftX, topLeftY, draw_en, active, crashing
  );

  modport slave (
    input  startOfFrame, initialX, spawn_en, speed,
    input  drift_en, collision, pause,
    output topLeftX, topLeftY, draw_en, active, crashing
  );
endinterface

// File: rtl/enemy_car_mover.sv
// Enemy car position generator: spawn, scroll, drift, crash blink, despawn.
// Y is kept in 18-bit signed fixed point; X in integer pixels.
module enemy_car_mover #(
  parameter int START_Y       = -64,
  parameter int SCREEN_BOTTOM = 480,
  parameter int X_MIN         = 160,
  parameter int X_MAX         = 440,
  parameter int FRAC_BITS     = 6,
  parameter int BASE_STEP     = 64,
  parameter int SPEED_STEP    = 32,
  parameter int CRASH_FRAMES  = 32
) (
  input logic        clk,
  input logic        reset,
  enemy_car_if.slave bus
);

  localparam int CW = $clog2(CRASH_FRAMES);
  localparam logic signed [17:0] Y0 =
    18'(START_Y * (1 << FRAC_BITS));
  localparam logic signed [17:0] Y_END =
    18'(SCREEN_BOTTOM * (1 << FRAC_BITS));
  localparam logic signed [10:0] XL = 11'(X_MIN);
  localparam logic signed [10:0] XH = 11'(X_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CRASH_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE, MOVE, CRASH
  } state_t;

  state_t             state, state_n;
  logic signed [17:0] yfp, yfp_n, ysum, step;
  logic signed [10:0] x, x_n, nx;
  logic               dir_neg, dir_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic               fev;
  logic signed [10:0] tly;
  logic               draw_q, active_q, crash_q;

  assign bus.topLeftX = x;
  assign bus.topLeftY = tly;
  assign bus.draw_en  = draw_q;
  assign bus.active   = active_q;
  assign bus.crashing = crash_q;

  always_comb begin
    state_n = state;
    yfp_n   = yfp;
    x_n     = x;
    dir_n   = dir_neg;
    cnt_n   = cnt;
    fev     = bus.startOfFrame & ~bus.pause;
    step    = 18'(BASE_STEP)
            + 18'(bus.speed) * 18'(SPEED_STEP);
    ysum    = yfp + step;
    nx      = dir_neg ? x - 11'sd1 : x + 11'sd1;
    unique case (state)
      IDLE: begin
        if (fev && bus.spawn_en) begin
          x_n     = bus.initialX;
          yfp_n   = Y0;
          dir_n   = 1'b0;
          state_n = MOVE;
        end
      end
      MOVE: begin
        // collision freezes position even on a frame edge
        if (bus.collision) begin
          state_n = CRASH;
          cnt_n   = '0;
        end else if (fev) begin
          yfp_n = ysum;
          if (bus.drift_en) begin
            if (nx > XH) begin
              x_n   = XH;
              dir_n = 1'b1;
            end else if (nx < XL) begin
              x_n   = XL;
              dir_n = 1'b0;
            end else begin
              x_n = nx;
            end
          end
          if (ysum >= Y_END) begin
            state_n = IDLE;
            yfp_n   = Y0;
          end
        end
      end
      CRASH: begin
        if (fev) begin
          cnt_n = cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state_n = IDLE;
            yfp_n   = Y0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      yfp      <= Y0;
      x        <= XL;
      dir_neg  <= 1'b0;
      cnt      <= '0;
      tly      <= 11'(START_Y);
      draw_q   <= 1'b0;
      active_q <= 1'b0;
      crash_q  <= 1'b0;
    end else begin
      state    <= state_n;
      yfp      <= yfp_n;
      x        <= x_n;
      dir_neg  <= dir_n;
      cnt      <= cnt_n;
      tly      <= 11'(yfp_n >>> FRAC_BITS);
      draw_q   <= (state_n == MOVE)
               | ((state_n == CRASH) & ~cnt_n[2]);
      active_q <= (state_n == MOVE);
      crash_q  <= (state_n == CRASH);
    end
  end

endmodule
